input_command_decoder: RTL

- Consumer-side counterpart of the input pulse stretcher. It takes the stretched or held 6-bit user button vector and turns each press into exactly one command token.
- The token carries a 3-bit index and is offered to the battle control FSM over a valid/ready handshake.
- Re-arms only after the input has been all-zero for a programmable number of consecutive cycles. This rejects stretched tails, bounce and multi-button chords.

---
 rtl/battle_input_pkg.sv | 32 +++
 rtl/onehot_index_encoder.sv | 15 +
 rtl/input_command_decoder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/battle_input_pkg.sv
// rtl/battle_input_pkg.sv - shared types and helpers for the battle input path
package battle_input_pkg;

  localparam int BTN_W  = 6;
  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    HELD    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  function automatic logic onehot_valid(input logic [BTN_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < BTN_W; i++) begin
      if (v[i]) n++;
    end
    return (n == 1);
  endfunction

  // Index is only meaningful for a one-hot vector; anything else reports 0.
  function automatic logic [CODE_W-1:0] onehot_index(input logic [BTN_W-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < BTN_W; i++) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return onehot_valid(v) ? idx : '0;
  endfunction

endpackage

// File: rtl/onehot_index_encoder.sv
// rtl/onehot_index_encoder.sv - combinational one-hot check and button index
module onehot_index_encoder
  import battle_input_pkg::*;
(
  input  logic [BTN_W-1:0]  vec_i,
  output logic              is_onehot_o,
  output logic [CODE_W-1:0] index_o
);

  always_comb begin
    is_onehot_o = onehot_valid(vec_i);
    index_o     = onehot_index(vec_i);
  end

endmodule

// File: rtl/input_command_decoder.sv
// rtl/input_command_decoder.sv - turns each stretched button press into one command token
module input_command_decoder
  import battle_input_pkg::*;
#(
  parameter int         WIDTH       = 6,
  parameter logic [7:0] IDLE_CYCLES = 8'd4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  userin,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [CODE_W-1:0] cmd_code,
  output logic [WIDTH-1:0]  cmd_onehot,
  output logic              invalid_pulse,
  output logic              drop_pulse,
  output logic              armed
);

  localparam logic [7:0] LAST_ZERO = IDLE_CYCLES - 8'd1;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [CODE_W-1:0] cmd_code_q, cmd_code_d;
  logic [WIDTH-1:0]  cmd_onehot_q, cmd_onehot_d;
  logic              invalid_q, invalid_d;
  logic              drop_q, drop_d;
  logic              armed_q;

  logic              is_onehot;
  logic [CODE_W-1:0] index;
  logic              press;
  logic              classify;
  logic              out_free;
  logic              load;

  onehot_index_encoder u_enc (
    .vec_i       (userin),
    .is_onehot_o (is_onehot),
    .index_o     (index)
  );

  assign press    = (userin != '0);
  assign classify = (state_q == ARMED) && press;
  assign out_free = !cmd_valid_q || cmd_ready;
  assign load     = classify && is_onehot && out_free;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARMED: begin
        if (press) state_d = HELD;
      end
      HELD: begin
        if (!press) begin
          if (IDLE_CYCLES == 8'd1) begin
            state_d = ARMED;
          end else begin
            state_d = RELEASE;
            cnt_d   = 8'd1;
          end
        end
      end
      RELEASE: begin
        // Any non-zero sample restarts the quiet-period count from scratch.
        if (press) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == LAST_ZERO) begin
          state_d = ARMED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = RELEASE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    cmd_valid_d  = cmd_valid_q;
    cmd_code_d   = cmd_code_q;
    cmd_onehot_d = cmd_onehot_q;
    invalid_d    = classify && !is_onehot;
    drop_d       = classify && is_onehot && !out_free;
    // A load on the same edge as a transfer keeps cmd_valid high.
    if (load) begin
      cmd_valid_d  = 1'b1;
      cmd_code_d   = index;
      cmd_onehot_d = userin;
    end else if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RELEASE;
      cnt_q        <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= '0;
      cmd_onehot_q <= '0;
      invalid_q    <= 1'b0;
      drop_q       <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
      cmd_onehot_q <= cmd_onehot_d;
      invalid_q    <= invalid_d;
      drop_q       <= drop_d;
      armed_q      <= (state_d == ARMED);
    end
  end

  assign cmd_valid     = cmd_valid_q;
  assign cmd_code      = cmd_code_q;
  assign cmd_onehot    = cmd_onehot_q;
  assign invalid_pulse = invalid_q;
  assign drop_pulse    = drop_q;
  assign armed         = armed_q;

endmodule
